// File: rtl/progmem_loader_pkg.sv
// Shared definitions for the program-memory loader: state encoding and datapath widths.
package progmem_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int CSUM_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/progmem_loader_if.sv
// Bundle of the loader's control, byte-stream and memory-port signals.
// The master modport is the loader's view; the slave modport is the host/memory view.
interface progmem_loader_if
    import progmem_loader_pkg::*;
#(
    parameter int A = 8,
    parameter int D = 8
);
    logic              start;
    logic              abort;
    logic [A-1:0]      base_addr;
    logic [A:0]        word_count;
    logic              s_valid;
    logic              s_ready;
    logic [BYTE_W-1:0] s_data;
    logic [A-1:0]      mem_addressw;
    logic [D-1:0]      mem_dbusw;
    logic              mem_we;
    logic [D-1:0]      mem_dbusr;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [CSUM_W-1:0] checksum;

    modport master (
        input  start, abort, base_addr, word_count, s_valid, s_data, mem_dbusr,
        output s_ready, mem_addressw, mem_dbusw, mem_we, cpu_hold, busy, done, error, checksum
    );

    modport slave (
        output start, abort, base_addr, word_count, s_valid, s_data, mem_dbusr,
        input  s_ready, mem_addressw, mem_dbusw, mem_we, cpu_hold, busy, done, error, checksum
    );

endinterface

// File: rtl/progmem_loader_packer.sv
// Byte-to-word packer: collects D/8 bytes little-endian and presents the finished word
// for one cycle. A clear drops any partially assembled word.
module progmem_packer
    import progmem_loader_pkg::*;
#(
    parameter int D = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [D-1:0]      word
);
    localparam int BPW   = D / BYTE_W;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [D-1:0]        shift_q, shift_d;
    logic [D-1:0]        word_q, word_d;
    logic                word_valid_q, word_valid_d;
    logic [D+BYTE_W-1:0] merged;

    // Shift each new byte in from the top so the first byte ends up in bits [7:0].
    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        merged       = {byte_data, shift_q};
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            shift_d = D'(merged >> BYTE_W);
            if (cnt_q == CNT_W'(BPW - 1)) begin
                cnt_d        = '0;
                word_d       = shift_d;
                word_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Packer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word       = word_q;

endmodule

// File: rtl/progmem_loader.sv
// Program-memory loader: streams bytes into consecutive memory words, then reads the
// loaded range back and compares its byte sum with the checksum of the stream.
module progmem_loader
    import progmem_loader_pkg::*;
#(
    parameter int A = 8,
    parameter int D = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    progmem_loader_if.master bus
);
    localparam int BPW   = D / BYTE_W;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int REM_W = A + 1 + CNT_W;
    localparam logic [A:0] MAX_WORDS = {1'b1, {A{1'b0}}};
    localparam logic [A:0] ONE_WORD  = {{A{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [A-1:0]      base_q, base_d;
    logic [A:0]        count_q, count_d;
    logic [A-1:0]      addr_q, addr_d;
    logic [A:0]        words_rem_q, words_rem_d;
    logic [REM_W-1:0]  bytes_rem_q, bytes_rem_d;
    logic [CSUM_W-1:0] csum_q, csum_d;
    logic [CSUM_W-1:0] rb_sum_q, rb_sum_d;
    logic              error_q, error_d;

    logic              count_bad;
    logic              count_zero;
    logic              s_ready;
    logic              accept;
    logic              write;
    logic              pk_clear;
    logic              pk_word_valid;
    logic [D-1:0]      pk_word;
    logic [CSUM_W-1:0] rb_add;

    progmem_packer #(.D(D)) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pk_clear),
        .byte_valid (accept),
        .byte_data  (bus.s_data),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    // Handshake, write strobe and read-back byte sum; abort suppresses both stream and write.
    always_comb begin
        count_bad  = (count_q > MAX_WORDS);
        count_zero = (count_q == '0);
        s_ready    = (state_q == ST_LOAD) && !bus.abort && !count_bad && (bytes_rem_q != '0);
        accept     = bus.s_valid && s_ready;
        write      = (state_q == ST_LOAD) && pk_word_valid && !bus.abort;
        pk_clear   = bus.abort || ((state_q == ST_IDLE) && bus.start);
        rb_add     = '0;
        for (int k = 0; k < BPW; k++) begin
            rb_add = rb_add + CSUM_W'(bus.mem_dbusr[k*BYTE_W +: BYTE_W]);
        end
    end

    // Next-state logic for the sequencer, address/word counters and both sums.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        addr_d      = addr_q;
        words_rem_d = words_rem_q;
        bytes_rem_d = bytes_rem_q;
        csum_d      = csum_q;
        rb_sum_d    = rb_sum_q;
        error_d     = error_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_LOAD;
                    base_d      = bus.base_addr;
                    count_d     = bus.word_count;
                    addr_d      = bus.base_addr;
                    words_rem_d = bus.word_count;
                    bytes_rem_d = REM_W'(bus.word_count) * REM_W'(BPW);
                    csum_d      = '0;
                    rb_sum_d    = '0;
                    error_d     = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.abort || count_bad) begin
                    state_d = ST_FINISH;
                    error_d = 1'b1;
                end else if (count_zero) begin
                    state_d = ST_FINISH;
                end else begin
                    if (accept) begin
                        csum_d      = csum_q + CSUM_W'(bus.s_data);
                        bytes_rem_d = bytes_rem_q - 1'b1;
                    end
                    if (write) begin
                        if (words_rem_q == ONE_WORD) begin
                            state_d     = ST_VERIFY;
                            addr_d      = base_q;
                            words_rem_d = count_q;
                            rb_sum_d    = '0;
                        end else begin
                            addr_d      = addr_q + 1'b1;
                            words_rem_d = words_rem_q - 1'b1;
                        end
                    end
                end
            end
            ST_VERIFY: begin
                if (bus.abort) begin
                    state_d = ST_FINISH;
                    error_d = 1'b1;
                end else begin
                    rb_sum_d    = rb_sum_q + rb_add;
                    addr_d      = addr_q + 1'b1;
                    words_rem_d = words_rem_q - 1'b1;
                    if (words_rem_q == ONE_WORD) begin
                        state_d = ST_FINISH;
                        error_d = (rb_sum_d != csum_q);
                    end
                end
            end
            ST_FINISH: begin
                // An abort landing on the done cycle still flags the load as failed,
                // but the done pulse is kept to a single cycle.
                state_d = ST_IDLE;
                if (bus.abort) begin
                    error_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            words_rem_q <= '0;
            bytes_rem_q <= '0;
            csum_q      <= '0;
            rb_sum_q    <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            words_rem_q <= words_rem_d;
            bytes_rem_q <= bytes_rem_d;
            csum_q      <= csum_d;
            rb_sum_q    <= rb_sum_d;
            error_q     <= error_d;
        end
    end

    assign bus.s_ready      = s_ready;
    assign bus.mem_addressw = addr_q;
    assign bus.mem_dbusw    = pk_word;
    assign bus.mem_we       = write;
    assign bus.cpu_hold     = (state_q != ST_IDLE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = (state_q == ST_FINISH);
    assign bus.error        = error_q;
    assign bus.checksum     = csum_q;

endmodule
